// File: rtl/pt_encoder_param.sv
// Parametrised trinary remote-control encoder: latches a word by valid/ready and sends it as REPEAT frames.
// Optional macro PT_ENC_FRAME_CNT_EN adds a 16-bit count of completed frames (frame_cnt).
module pt_encoder_param #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 4,
   parameter int CHIP_CYC  = 4,
   parameter int REPEAT    = 4
) (
   input  logic                   clk_12kHz,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*ADDR_BITS-1:0] addr_code,
   input  logic [DATA_BITS-1:0]   data_in,
   output logic                   dout,
   output logic                   busy,
   output logic                   sync_flag,
   output logic                   done
`ifdef PT_ENC_FRAME_CNT_EN
   ,
   output logic [15:0]            frame_cnt
`endif
);

   localparam int NSYM  = ADDR_BITS + DATA_BITS;
   localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam int CYC_W = (CHIP_CYC > 1) ? $clog2(CHIP_CYC) : 1;
   localparam int REP_W = $clog2(REPEAT + 1);

   typedef enum logic [1:0] {IDLE, BIT, SYNC} state_t;

   state_t                 state, state_nxt;
   logic [CYC_W-1:0]       cyc, cyc_nxt;
   logic [4:0]             chip, chip_nxt;
   logic [SYM_W-1:0]       sym, sym_nxt;
   logic [REP_W-1:0]       rep, rep_nxt;
   logic                   done_nxt;
   logic                   cyc_wrap;
   logic [2*ADDR_BITS-1:0] addr_q;
   logic [DATA_BITS-1:0]   data_q;
   logic [1:0]             code;
   logic                   sym_one;
   logic                   sym_float;
   logic                   bit_chip;

   assign cyc_wrap = (cyc == CYC_W'(CHIP_CYC - 1));

   always_ff @(posedge clk_12kHz) begin
      if (!rst_n) begin
         state <= IDLE;
         cyc   <= '0;
         chip  <= '0;
         sym   <= '0;
         rep   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cyc   <= cyc_nxt;
         chip  <= chip_nxt;
         sym   <= sym_nxt;
         rep   <= rep_nxt;
         done  <= done_nxt;
      end
   end

   // The word is held for all repeats so the inputs are free once accepted.
   always_ff @(posedge clk_12kHz) begin
      if (state == IDLE && in_valid) begin
         addr_q <= addr_code;
         data_q <= data_in;
      end
   end

   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc;
      chip_nxt  = chip;
      sym_nxt   = sym;
      rep_nxt   = rep;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = BIT;
               cyc_nxt   = '0;
               chip_nxt  = '0;
               sym_nxt   = '0;
               rep_nxt   = '0;
            end
         end
         BIT: begin
            cyc_nxt = cyc_wrap ? '0 : cyc + CYC_W'(1);
            if (cyc_wrap) begin
               if (chip == 5'd7) begin
                  chip_nxt = '0;
                  if (sym == SYM_W'(NSYM - 1)) begin
                     state_nxt = SYNC;
                     sym_nxt   = '0;
                  end else begin
                     sym_nxt = sym + SYM_W'(1);
                  end
               end else begin
                  chip_nxt = chip + 5'd1;
               end
            end
         end
         SYNC: begin
            cyc_nxt = cyc_wrap ? '0 : cyc + CYC_W'(1);
            if (cyc_wrap) begin
               if (chip == 5'd31) begin
                  chip_nxt = '0;
                  if (rep == REP_W'(REPEAT - 1)) begin
                     state_nxt = IDLE;
                     rep_nxt   = '0;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = BIT;
                     rep_nxt   = rep + REP_W'(1);
                  end
               end else begin
                  chip_nxt = chip + 5'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Data bits are mapped onto the same 2-bit code as address symbols ('0' or '1').
   always_comb begin
      code = 2'b00;
      for (int i = 0; i < ADDR_BITS; i++) begin
         if (sym == SYM_W'(i)) code = addr_q[2*i +: 2];
      end
      for (int j = 0; j < DATA_BITS; j++) begin
         if (sym == SYM_W'(ADDR_BITS + DATA_BITS - 1 - j)) code = {1'b0, data_q[j]};
      end
   end

   assign sym_one   = (code == 2'b01);
   assign sym_float = code[1];
   // Chips 0/4 always high, 3/7 always low; the middle pairs carry the symbol value.
   assign bit_chip  = (chip[1:0] == 2'b00) |
                      ((chip[1:0] != 2'b11) & (sym_one | (sym_float & chip[2])));

   assign dout      = (state == BIT) ? bit_chip : ((state == SYNC) && (chip == 5'd0));
   assign busy      = (state != IDLE);
   assign sync_flag = (state == SYNC);
   assign in_ready  = (state == IDLE);

`ifdef PT_ENC_FRAME_CNT_EN
   logic frame_end;
   assign frame_end = (state == SYNC) && cyc_wrap && (chip == 5'd31);

   always_ff @(posedge clk_12kHz) begin
      if (!rst_n)         frame_cnt <= '0;
      else if (frame_end) frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pt_encoder_param.sv
// Randomized bench for pt_encoder_param: default instance plus a parameter-sweep instance,
// both checked against an arithmetic waveform model.
module tb_pt_encoder_param;

   localparam int AB = 8;
   localparam int DB = 4;
   localparam int CC = 4;
   localparam int RP = 4;
   localparam int FL = (AB + DB) * 8 * CC + 32 * CC;
   localparam int AB2 = 12;
   localparam int DB2 = 6;
   localparam int CC2 = 2;
   localparam int FL2 = 352;

   logic            clk_12kHz = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [2*AB-1:0] addr_code = '0;
   logic [DB-1:0]   data_in = '0;
   logic            in_ready, dout, busy, sync_flag, done;

   logic             in_valid2 = 1'b0;
   logic [2*AB2-1:0] addr_code2 = '0;
   logic [DB2-1:0]   data_in2 = '0;
   logic             in_ready2, dout2, busy2, sync_flag2, done2;

`ifdef PT_ENC_FRAME_CNT_EN
   logic [15:0] frame_cnt, frame_cnt2;
   int          expFrames = 0;
`endif

   int checks = 0;
   int errors = 0;

   pt_encoder_param dut (
      .clk_12kHz(clk_12kHz), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .addr_code(addr_code), .data_in(data_in), .dout(dout), .busy(busy),
      .sync_flag(sync_flag), .done(done)
`ifdef PT_ENC_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   pt_encoder_param #(.ADDR_BITS(AB2), .DATA_BITS(DB2), .CHIP_CYC(CC2), .REPEAT(1)) dut2 (
      .clk_12kHz(clk_12kHz), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .addr_code(addr_code2), .data_in(data_in2), .dout(dout2), .busy(busy2),
      .sync_flag(sync_flag2), .done(done2)
`ifdef PT_ENC_FRAME_CNT_EN
      , .frame_cnt(frame_cnt2)
`endif
   );

   always #5 clk_12kHz = ~clk_12kHz;

   // Expected dout for cycle k (0 = first cycle after the handshake) of a transfer.
   function automatic logic refDout(input int ab, input int db, input int cc,
                                    input logic [63:0] addr, input logic [31:0] data, input int k);
      int fl, bitLen, p, s, c;
      logic [7:0] pat;
      fl     = (ab + db) * 8 * cc + 32 * cc;
      bitLen = (ab + db) * 8 * cc;
      p      = k % fl;
      if (p >= bitLen) return (p - bitLen) < cc;
      s = p / (8 * cc);
      c = (p / cc) % 8;
      if (s < ab) begin
         case (addr[2*s +: 2])
            2'b00:   pat = 8'b10001000;
            2'b01:   pat = 8'b11101110;
            default: pat = 8'b10001110;
         endcase
      end else begin
         pat = data[db - 1 - (s - ab)] ? 8'b11101110 : 8'b10001000;
      end
      return pat[7 - c];
   endfunction

   function automatic logic refSync(input int ab, input int db, input int cc, input int k);
      int fl;
      fl = (ab + db) * 8 * cc + 32 * cc;
      return (k % fl) >= (ab + db) * 8 * cc;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_12kHz);
      #1;
   endtask

   task automatic applyStimulus(input logic [2*AB-1:0] a, input logic [DB-1:0] d, input logic v);
      addr_code = a;
      data_in   = d;
      in_valid  = v;
   endtask

   // Handshake on the next edge, then check ncyc cycles of the transfer.
   task automatic runWord(input logic [2*AB-1:0] a, input logic [DB-1:0] d, input int ncyc,
                          input logic holdNext, input logic [2*AB-1:0] na, input logic [DB-1:0] nd);
      int doutErr, stateErr, syncCnt, doneCnt;
      doutErr = 0; stateErr = 0; syncCnt = 0; doneCnt = 0;
      applyStimulus(a, d, 1'b1);
      tick();
      if (holdNext) applyStimulus(na, nd, 1'b1);
      else          applyStimulus(16'($urandom), 4'($urandom), 1'b0);
      for (int k = 0; k < ncyc; k++) begin
         if (dout !== refDout(AB, DB, CC, 64'(a), 32'(d), k)) doutErr++;
         if (sync_flag !== refSync(AB, DB, CC, k)) stateErr++;
         if (busy !== 1'b1 || in_ready !== 1'b0) stateErr++;
         syncCnt += int'(sync_flag);
         doneCnt += int'(done);
         if (k % FL == FL - 1) begin
            checkOutput($sformatf("frame%0d dout errs", k / FL), 32'(doutErr), 0);
            checkOutput($sformatf("frame%0d sync cycles", k / FL), 32'(syncCnt), 32 * CC);
            doutErr = 0;
            syncCnt = 0;
         end
         if (!holdNext) begin
            addr_code = 16'($urandom);
            data_in   = 4'($urandom);
         end
         tick();
      end
      checkOutput("busy/ready/sync errs", 32'(stateErr), 0);
      checkOutput("early done", 32'(doneCnt), 0);
   endtask

   task automatic checkEnd();
      checkOutput("done pulse", 32'(done), 1);
      checkOutput("ready at done", 32'(in_ready), 1);
      checkOutput("busy at done", 32'(busy), 0);
      checkOutput("dout at done", 32'(dout), 0);
`ifdef PT_ENC_FRAME_CNT_EN
      expFrames += RP;
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(expFrames));
`endif
   endtask

   initial begin
      logic [2*AB-1:0] a1, a2;
      logic [DB-1:0]   d1, d2;
      int              idleErr, doneCnt, busyCnt;

      $display("[TB] reset and idle");
      rst_n = 1'b0;
      tick();
      tick();
      checkOutput("reset dout", 32'(dout), 0);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset in_ready", 32'(in_ready), 1);
      checkOutput("reset done", 32'(done), 0);
      checkOutput("reset sync_flag", 32'(sync_flag), 0);
`ifdef PT_ENC_FRAME_CNT_EN
      checkOutput("reset frame_cnt", 32'(frame_cnt), 0);
`endif
      rst_n = 1'b1;
      idleErr = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (dout !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) idleErr++;
      end
      checkOutput("idle errs", 32'(idleErr), 0);

      $display("[TB] single word, all-zero address");
      runWord(16'h0000, 4'b1010, RP * FL, 1'b0, '0, '0);
      checkEnd();

      $display("[TB] trinary address");
      runWord({2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01}, 4'($urandom),
              RP * FL, 1'b0, '0, '0);
      checkEnd();

      $display("[TB] back-pressure");
      a1 = 16'($urandom); d1 = 4'($urandom);
      a2 = 16'($urandom); d2 = ~d1;
      runWord(a1, d1, RP * FL, 1'b1, a2, d2);
      checkEnd();
      runWord(a2, d2, RP * FL, 1'b0, '0, '0);
      checkEnd();

      $display("[TB] reset mid-operation");
      runWord(16'($urandom), 4'($urandom), FL + 300, 1'b0, '0, '0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("midreset dout", 32'(dout), 0);
      checkOutput("midreset busy", 32'(busy), 0);
      checkOutput("midreset in_ready", 32'(in_ready), 1);
`ifdef PT_ENC_FRAME_CNT_EN
      expFrames = 0;
      checkOutput("midreset frame_cnt", 32'(frame_cnt), 0);
`endif
      doneCnt = int'(done);
      for (int i = 0; i < 20; i++) begin
         tick();
         doneCnt += int'(done) + int'(busy);
      end
      checkOutput("midreset no done", 32'(doneCnt), 0);
      runWord(16'($urandom), 4'($urandom), RP * FL, 1'b0, '0, '0);
      checkEnd();

      $display("[TB] parameter sweep instance");
      addr_code2 = 24'($urandom);
      data_in2   = 6'($urandom);
      in_valid2  = 1'b1;
      tick();
      in_valid2 = 1'b0;
      idleErr = 0; doneCnt = 0; busyCnt = 0;
      for (int k = 0; k < FL2 + 4; k++) begin
         if (k < FL2 && dout2 !== refDout(AB2, DB2, CC2, 64'(addr_code2), 32'(data_in2), k))
            idleErr++;
         busyCnt += int'(busy2);
         doneCnt += int'(done2);
         if (k == FL2) checkOutput("sweep done at end", 32'(done2), 1);
         tick();
      end
      checkOutput("sweep dout errs", 32'(idleErr), 0);
      checkOutput("sweep frame length", 32'(busyCnt), FL2);
      checkOutput("sweep done count", 32'(doneCnt), 1);
`ifdef PT_ENC_FRAME_CNT_EN
      checkOutput("sweep frame_cnt", 32'(frame_cnt2), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
